// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - bit positions inside the EX/MEM M and WB control bundles
//   - state encoding of the data-memory access FSM
package mem_access_stage_pkg;

  localparam int M_BRANCH    = 2;
  localparam int M_READ      = 1;
  localparam int M_WRITE     = 0;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/define.sv
// Global build-wide macros shared by the MEM stage RTL.
//   DATA_WIDTH : width of data words, byte addresses and branch targets
//   RST_VALID  : level of rst that means "in reset"
`ifndef DEFINE_SV
`define DEFINE_SV

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

`ifndef RST_VALID
`define RST_VALID 1'b1
`endif

`endif

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB pipeline register.
// Ports:
//   clk, rst               clock and synchronous reset (active at `RST_VALID)
//   i_stall                insert a bubble: WB control cleared, other fields hold
//   i_kill                 retire the instruction with its WB control cleared
//   i_rdata_en             capture i_rdata into o_rdata this edge
//   i_WB, i_we, i_result   control, destination and ALU result from MEM
//   i_rdata                load data from the MEM read buffer
//   o_WB, o_we, o_result, o_rdata   registered MEM/WB outputs
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RST_VALID
`define RST_VALID 1'b1
`endif

module mem_wb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_kill,
  input  logic                  i_rdata_en,
  input  logic [1:0]            i_WB,
  input  logic [4:0]            i_we,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [1:0]            o_WB,
  output logic [4:0]            o_we,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [1:0]            r_wb;
  logic [4:0]            r_we;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_rdata;

  // A stalled cycle must not let the held instruction write back twice,
  // so only the WB control is cleared; the data fields simply hold.
  always_ff @(posedge clk) begin
    if (rst == `RST_VALID) begin
      r_wb     <= '0;
      r_we     <= '0;
      r_result <= '0;
      r_rdata  <= '0;
    end else begin
      if (i_stall) begin
        r_wb <= '0;
      end else begin
        r_wb[WB_REGWRITE] <= i_WB[WB_REGWRITE] & ~i_kill;
        r_wb[WB_MEMTOREG] <= i_WB[WB_MEMTOREG] & ~i_kill;
        r_we              <= i_we;
        r_result          <= i_result;
      end
      if (i_rdata_en) begin
        r_rdata <= i_rdata;
      end
    end
  end

  assign o_WB     = r_wb;
  assign o_we     = r_we;
  assign o_result = r_result;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word loads/stores over a req/ack data bus, branch
// resolution, and the MEM/WB register.
// Ports:
//   clk, rst                      clock, synchronous reset (active at `RST_VALID)
//   i_M, i_WB                     EX/MEM control bundles ({branch,read,write}, {reg_write,mem_to_reg})
//   i_zero_valid                  ALU zero flag
//   i_result, i_we, i_wdata       ALU result / byte address, destination, store data
//   i_imme                        branch target
//   o_stall                       freeze upstream registers and PC
//   o_pcsrc, o_branch_target      branch decision and target
//   dmem_req/wr/addr/wdata        registered data-memory request
//   dmem_rdata, dmem_ack          data-memory response
//   o_WB, o_we, o_result, o_rdata MEM/WB register outputs
//   o_mem_err                     sticky access error flag
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RST_VALID
`define RST_VALID 1'b1
`endif

module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            i_M,
  input  logic [1:0]            i_WB,
  input  logic                  i_zero_valid,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic [4:0]            i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_imme,
  output logic                  o_stall,
  output logic                  o_pcsrc,
  output logic [DATA_WIDTH-1:0] o_branch_target,
  output logic                  dmem_req,
  output logic                  dmem_wr,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ack,
  output logic [1:0]            o_WB,
  output logic [4:0]            o_we,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_mem_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_count;
  logic                  r_abort;
  logic                  r_mem_err;
  logic [DATA_WIDTH-1:0] r_rd_buf;
  logic                  r_req;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_mem_op;
  logic w_illegal;
  logic w_issue;
  logic w_timeout;
  logic w_kill;

  // Only aligned words with exactly one of read/write are legal accesses.
  assign w_mem_op  = i_M[M_READ] | i_M[M_WRITE];
  assign w_illegal = w_mem_op & ((i_result[1:0] != 2'b00) | (i_M[M_READ] & i_M[M_WRITE]));
  assign w_issue   = (r_state == IDLE) & w_mem_op & ~w_illegal;
  // Ack wins over timeout when both land in the last WAIT cycle.
  assign w_timeout = (r_state == WAIT) & ~dmem_ack & (r_count == CNT_LAST);
  assign w_kill    = r_abort | w_illegal;

  assign o_pcsrc         = i_M[M_BRANCH] & i_zero_valid;
  assign o_branch_target = i_imme;

  always_comb begin
    w_state_next = r_state;
    o_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          o_stall      = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        o_stall = 1'b1;
        if (dmem_ack || w_timeout) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == `RST_VALID) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bus request, timeout counter, abort and error tracking. An ack seen
  // outside WAIT (e.g. after a timeout) falls through untouched.
  always_ff @(posedge clk) begin
    if (rst == `RST_VALID) begin
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_count   <= '0;
      r_abort   <= 1'b0;
      r_mem_err <= 1'b0;
      r_rd_buf  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_req   <= 1'b1;
            r_wr    <= i_M[M_WRITE];
            r_addr  <= i_result;
            r_wdata <= i_wdata;
            r_count <= '0;
          end else if (w_illegal) begin
            r_mem_err <= 1'b1;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            r_req    <= 1'b0;
            r_rd_buf <= dmem_rdata;
          end else if (w_timeout) begin
            r_req     <= 1'b0;
            r_abort   <= 1'b1;
            r_mem_err <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        DONE: begin
          r_abort <= 1'b0;
        end
        default: begin
          r_req <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_wr    = r_wr;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign o_mem_err  = r_mem_err;

  mem_wb_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .i_stall    (o_stall),
    .i_kill     (w_kill),
    .i_rdata_en (r_state == DONE),
    .i_WB       (i_WB),
    .i_we       (i_we),
    .i_result   (i_result),
    .i_rdata    (r_rd_buf),
    .o_WB       (o_WB),
    .o_we       (o_we),
    .o_result   (o_result),
    .o_rdata    (o_rdata)
  );

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM pipeline stage directly downstream of the EX/MEM register. It consumes EX/MEM control (M, WB), ALU result, store data, destination register and branch target. It performs word loads and stores over a req/ack data-memory bus, stalling the upstream pipeline until the access completes. It resolves branches and registers the MEM/WB outputs for writeback.

Parameters:
DATA_WIDTH, `DATA_WIDTH from define.sv, width of data, address and target.
TIMEOUT_CYCLES, 16, WAIT cycles without ack before the access is aborted (>=1).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high (asserted when rst == `RST_VALID)
i_M  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
i_WB  in  2  [1]=reg_write, [0]=mem_to_reg
i_zero_valid  in  1  ALU zero flag
i_result  in  DATA_WIDTH  ALU result / memory byte address
i_we  in  5  destination register index
i_wdata  in  DATA_WIDTH  store data
i_imme  in  DATA_WIDTH  branch target
o_stall  out  1  freeze all upstream stage registers and PC this cycle
o_pcsrc  out  1  branch taken
o_branch_target  out  DATA_WIDTH  = i_imme
dmem_req  out  1  bus request, registered
dmem_wr  out  1  1=write, registered
dmem_addr  out  DATA_WIDTH  registered
dmem_wdata  out  DATA_WIDTH  registered
dmem_rdata  in  DATA_WIDTH  read data, valid with ack
dmem_ack  in  1  one-cycle completion strobe
o_WB  out  2  MEM/WB control
o_we  out  5  MEM/WB destination
o_result  out  DATA_WIDTH  MEM/WB ALU result
o_rdata  out  DATA_WIDTH  MEM/WB load data
o_mem_err  out  1  sticky: misaligned, read+write both set, or timeout

Behaviour:
- Reset: state IDLE; all outputs 0; wait counter 0; read buffer 0.
- mem_op = i_M[1] | i_M[0]. illegal = mem_op & (i_result[1:0] != 0 | (i_M[1] & i_M[0])).
- o_pcsrc = i_M[2] & i_zero_valid (combinational). o_branch_target = i_imme.
- FSM IDLE/WAIT/DONE:
  - IDLE, mem_op & ~illegal: o_stall=1. Next: dmem_req<=1, dmem_wr<=i_M[0], dmem_addr<=i_result, dmem_wdata<=i_wdata, counter<=0, go WAIT.
  - IDLE, illegal: no bus access, o_stall=0, o_mem_err<=1, MEM/WB captures with o_WB<=0.
  - WAIT: o_stall=1. If dmem_ack: dmem_req<=0, rd_buf<=dmem_rdata, go DONE. Else if counter==TIMEOUT_CYCLES-1: dmem_req<=0, set abort, o_mem_err<=1, go DONE. Else counter++.
  - DONE: o_stall=0; go IDLE. Inputs still hold the same instruction; it is not re-issued.
- Minimum load/store latency: 2 stall cycles (IDLE issue, WAIT with ack), instruction retires in DONE.
- MEM/WB register, each edge:
  - if o_stall: o_WB<=0 (bubble); other fields hold.
  - else: o_we<=i_we, o_result<=i_result, o_WB<=(abort|illegal ? 0 : i_WB).
  - o_rdata<=rd_buf in DONE, else dmem_rdata is not used and o_rdata holds.
- abort clears on leaving DONE. dmem_ack in IDLE or DONE is ignored (late ack after timeout).
- dmem_req stays high from the first WAIT cycle through the ack cycle; address and data are stable while req is high.
- rst in any state: next cycle IDLE, dmem_req=0, all outputs 0, o_mem_err cleared.
- Non-memory instructions: zero stall, single-cycle pass-through to MEM/WB.

Decomposition:
- Shared package: M/WB bit-index constants (M_BRANCH=2, M_READ=1, M_WRITE=0, WB_REGWRITE=1, WB_MEMTOREG=0) and the FSM state enum (IDLE, WAIT, DONE). DATA_WIDTH and RST_VALID stay in define.sv.
- One sub-module: mem_wb_reg, the MEM/WB register with stall-bubble and kill inputs.

Test Plan:
- ALU op: i_M=0, i_WB=2'b10, i_result=0x1234, i_we=5 -> o_stall never 1; next cycle o_WB=2'b10, o_result=0x1234, o_we=5.
- Load with ack on the first WAIT cycle: i_M=3'b010, addr=0x40, dmem_rdata=0xDEADBEEF -> o_stall=1 for exactly 2 cycles, dmem_req high 1 cycle, o_WB=0 during stall, then o_rdata=0xDEADBEEF, o_WB=2'b11.
- Store with ack after 3 WAIT cycles: i_M=3'b001, addr=0x80, wdata=0xA5 -> dmem_wr=1, addr and data stable 3 cycles, stall 4 cycles, o_mem_err=0.
- Timeout with TIMEOUT_CYCLES=4 and no ack -> req drops after 4 WAIT cycles, o_mem_err=1, retired o_WB=0; a late ack 2 cycles later is ignored.
- Misaligned load at addr=0x42 -> no dmem_req, no stall, o_mem_err=1, o_WB=0.
- Branch i_M=3'b100, zero=1, i_imme=0x200 -> o_pcsrc=1, target=0x200. Then rst asserted mid-WAIT -> next cycle req=0, state IDLE, all outputs 0.
